// File: rtl/midi_msg_parser.sv
// MIDI byte-stream to channel-voice message assembler with running status,
// realtime transparency, sysex discard and an optional channel filter.
module midi_msg_parser #(
    parameter int unsigned CHANNEL = 0,
    parameter bit          OMNI    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       msg_valid,
    output logic [2:0] msg_kind,
    output logic [3:0] msg_chan,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic       stray
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_D1, ST_WAIT_D2, ST_SYSEX} state_t;

    state_t     r_state, w_state_nx;
    logic [7:0] r_run_status, w_run_nx;
    logic [6:0] r_d1, w_d1_nx;
    logic       w_emit, w_stray, w_accept;
    logic [6:0] w_out_d1, w_out_d2;
    logic [2:0] w_kind;

    // Byte classification and next-state decode
    always_comb begin
        w_state_nx = r_state;
        w_run_nx   = r_run_status;
        w_d1_nx    = r_d1;
        w_emit     = 1'b0;
        w_stray    = 1'b0;
        w_out_d1   = r_d1;
        w_out_d2   = 7'd0;
        if (din_valid) begin
            if (!din[7]) begin
                case (r_state)
                    ST_IDLE: w_stray = 1'b1;
                    ST_WAIT_D1: begin
                        w_d1_nx  = din[6:0];
                        w_out_d1 = din[6:0];
                        if (r_run_status[7:4] == 4'hC || r_run_status[7:4] == 4'hD) begin
                            w_emit = 1'b1;
                        end else begin
                            w_state_nx = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        w_out_d2   = din[6:0];
                        w_emit     = 1'b1;
                        w_state_nx = ST_WAIT_D1;
                    end
                    default: ;
                endcase
            end else if (din < 8'hF0) begin
                w_run_nx   = din;
                w_state_nx = ST_WAIT_D1;
            end else if (din == 8'hF0) begin
                w_run_nx   = 8'd0;
                w_state_nx = ST_SYSEX;
            end else if (din <= 8'hF7) begin
                w_run_nx   = 8'd0;
                w_state_nx = ST_IDLE;
            end
        end
    end

    // Status 0x8..0xE maps to kind 0..6; note-on with zero velocity becomes note-off
    assign w_kind   = (r_run_status[6:4] == 3'd1 && w_out_d2 == 7'd0) ? 3'd0 : r_run_status[6:4];
    assign w_accept = OMNI || (r_run_status[3:0] == 4'(CHANNEL));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_run_status <= 8'd0;
            r_d1         <= 7'd0;
        end else begin
            r_state      <= w_state_nx;
            r_run_status <= w_run_nx;
            r_d1         <= w_d1_nx;
        end
    end

    // Message record holds until the next accepted message
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msg_valid <= 1'b0;
            msg_kind  <= 3'd0;
            msg_chan  <= 4'd0;
            msg_data1 <= 7'd0;
            msg_data2 <= 7'd0;
            stray     <= 1'b0;
        end else begin
            msg_valid <= w_emit && w_accept;
            stray     <= w_stray;
            if (w_emit && w_accept) begin
                msg_kind  <= w_kind;
                msg_chan  <= r_run_status[3:0];
                msg_data1 <= w_out_d1;
                msg_data2 <= w_out_d2;
            end
        end
    end
endmodule

// File: tb/tb_midi_msg_parser.sv
// Self-checking bench: two parsers (omni, and channel-5 filtered) share one byte stream.
module tb_midi_msg_parser;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din = 8'd0;
    logic       din_valid = 1'b0;

    logic       a_valid, a_stray, b_valid, b_stray;
    logic [2:0] a_kind, b_kind;
    logic [3:0] a_chan, b_chan;
    logic [6:0] a_d1, a_d2, b_d1, b_d2;

    int checks = 0;
    int errors = 0;

    logic [20:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
    int stray_a = 0, stray_b = 0, exp_stray = 0;

    // Reference model state: abstract "have status / collected data bytes" view
    bit          m_have = 1'b0, m_sysex = 1'b0;
    logic [7:0]  m_status = 8'd0;
    logic [6:0]  m_q[$];
    logic [20:0] m_last_a = 21'd0, m_last_b = 21'd0;

    always #5 clk = ~clk;

    midi_msg_parser #(.CHANNEL(0), .OMNI(1'b1)) dut_a (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .msg_valid(a_valid), .msg_kind(a_kind), .msg_chan(a_chan),
        .msg_data1(a_d1), .msg_data2(a_d2), .stray(a_stray)
    );

    midi_msg_parser #(.CHANNEL(5), .OMNI(1'b0)) dut_b (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .msg_valid(b_valid), .msg_kind(b_kind), .msg_chan(b_chan),
        .msg_data1(b_d1), .msg_data2(b_d2), .stray(b_stray)
    );

    always @(negedge clk) begin
        if (a_valid) got_a.push_back({a_kind, a_chan, a_d1, a_d2});
        if (b_valid) got_b.push_back({b_kind, b_chan, b_d1, b_d2});
        if (a_stray) stray_a++;
        if (b_stray) stray_b++;
    end

    function automatic logic [20:0] rec(input logic [2:0] k, input logic [3:0] c,
                                        input logic [6:0] d1, input logic [6:0] d2);
        return {k, c, d1, d2};
    endfunction

    task automatic model_reset();
        m_have = 1'b0; m_sysex = 1'b0; m_status = 8'd0; m_q.delete();
        m_last_a = 21'd0; m_last_b = 21'd0;
    endtask

    task automatic model_step(input logic [7:0] b);
        int          need;
        logic [2:0]  k;
        logic [6:0]  d2;
        logic [20:0] r;
        if (b >= 8'hF8) return;
        if (!b[7]) begin
            if (m_have) begin
                m_q.push_back(b[6:0]);
                need = (m_status[7:4] == 4'hC || m_status[7:4] == 4'hD) ? 1 : 2;
                if (m_q.size() == need) begin
                    k  = 3'(m_status[7:4] - 4'd8);
                    d2 = (need == 2) ? m_q[1] : 7'd0;
                    if (k == 3'd1 && d2 == 7'd0) k = 3'd0;
                    r = rec(k, m_status[3:0], m_q[0], d2);
                    exp_a.push_back(r); m_last_a = r;
                    if (m_status[3:0] == 4'd5) begin exp_b.push_back(r); m_last_b = r; end
                    m_q.delete();
                end
            end else if (!m_sysex) begin
                exp_stray++;
            end
        end else if (b < 8'hF0) begin
            m_have = 1'b1; m_sysex = 1'b0; m_status = b; m_q.delete();
        end else begin
            m_have = 1'b0; m_sysex = (b == 8'hF0); m_q.delete();
        end
    endtask

    task automatic send_seq(input bq_t s);
        foreach (s[i]) begin
            @(negedge clk);
            din = s[i]; din_valid = 1'b1;
            model_step(s[i]);
        end
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic clear_logs();
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
        stray_a = 0; stray_b = 0; exp_stray = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        din_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({a_valid, a_kind, a_chan, a_d1, a_d2, a_stray} !== 23'd0 ||
            {b_valid, b_kind, b_chan, b_d1, b_d2, b_stray} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs a=%h b=%h required 0",
                     {a_valid, a_kind, a_chan, a_d1, a_d2, a_stray},
                     {b_valid, b_kind, b_chan, b_d1, b_d2, b_stray});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({a_valid, a_kind, a_chan, a_d1, a_d2, a_stray} !== 23'd0) begin
            errors++;
            $display("FAIL reset_state a=%h required 0", {a_valid, a_kind, a_chan, a_d1, a_d2, a_stray});
        end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_note_on();
        clear_logs();
        @(negedge clk); din = 8'h93; din_valid = 1'b1; model_step(din);
        @(negedge clk); din = 8'h3C; model_step(din);
        @(negedge clk); din = 8'h64; model_step(din);
        @(negedge clk); din_valid = 1'b0;
        checks++;
        if (a_valid !== 1'b1) begin errors++; $display("FAIL note_on_latency valid=%b required 1", a_valid); end
        @(negedge clk);
        checks++;
        if (a_valid !== 1'b0) begin errors++; $display("FAIL note_on_width valid=%b required 0", a_valid); end
        checks++;
        if (got_a.size() != 1 || got_a[0] !== rec(3'd1, 4'd3, 7'h3C, 7'h64)) begin
            errors++; $display("FAIL note_on_record n=%0d rec=%h required %h", got_a.size(), got_a[0], rec(3'd1, 4'd3, 7'h3C, 7'h64));
        end
    endtask

    task automatic test_running_status();
        bq_t s;
        clear_logs();
        s = '{8'h90, 8'h40, 8'h7F, 8'h40, 8'h00};
        send_seq(s);
        repeat (2) @(negedge clk);
        checks++;
        if (got_a.size() != 2 || got_a[0] !== rec(3'd1, 4'd0, 7'h40, 7'h7F) || got_a[1] !== rec(3'd0, 4'd0, 7'h40, 7'h00)) begin
            errors++; $display("FAIL running_status n=%0d r0=%h r1=%h required 2 records", got_a.size(), got_a[0], got_a[1]);
        end
    endtask

    task automatic test_realtime();
        bq_t s;
        clear_logs();
        s = '{8'hB1, 8'hF8, 8'h07, 8'hFE, 8'h55};
        send_seq(s);
        repeat (2) @(negedge clk);
        checks++;
        if (got_a.size() != 1 || got_a[0] !== rec(3'd3, 4'd1, 7'h07, 7'h55)) begin
            errors++; $display("FAIL realtime_interleave n=%0d rec=%h required %h", got_a.size(), got_a[0], rec(3'd3, 4'd1, 7'h07, 7'h55));
        end
    endtask

    task automatic test_one_byte_abort();
        bq_t s;
        clear_logs();
        s = '{8'hC2, 8'h05, 8'hE0, 8'h10, 8'h90, 8'h30, 8'h20};
        send_seq(s);
        repeat (2) @(negedge clk);
        checks++;
        if (got_a.size() != 2 || got_a[0] !== rec(3'd4, 4'd2, 7'h05, 7'h00) || got_a[1] !== rec(3'd1, 4'd0, 7'h30, 7'h20)) begin
            errors++; $display("FAIL one_byte_abort n=%0d r0=%h r1=%h required 2 records", got_a.size(), got_a[0], got_a[1]);
        end
        checks++;
        if (a_kind !== 3'd1 || a_d1 !== 7'h30) begin
            errors++; $display("FAIL hold_after_abort kind=%0d d1=%h required 1/30", a_kind, a_d1);
        end
    endtask

    task automatic test_stray_sysex();
        bq_t s;
        pulse_reset();
        clear_logs();
        s = '{8'h12};
        send_seq(s);
        repeat (2) @(negedge clk);
        checks++;
        if (stray_a != 1 || got_a.size() != 0) begin
            errors++; $display("FAIL stray_idle strays=%0d msgs=%0d required 1/0", stray_a, got_a.size());
        end
        clear_logs();
        s = '{8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h22};
        send_seq(s);
        repeat (2) @(negedge clk);
        checks++;
        if (stray_a != 1 || got_a.size() != 0) begin
            errors++; $display("FAIL sysex_stray strays=%0d msgs=%0d required 1/0", stray_a, got_a.size());
        end
    endtask

    task automatic test_filter();
        bq_t s;
        clear_logs();
        s = '{8'h94, 8'h3C, 8'h64};
        send_seq(s);
        repeat (2) @(negedge clk);
        checks++;
        if (got_b.size() != 0 || got_a.size() != 1) begin
            errors++; $display("FAIL filter_other_chan b_msgs=%0d a_msgs=%0d required 0/1", got_b.size(), got_a.size());
        end
        clear_logs();
        s = '{8'h95, 8'h3C};
        send_seq(s);
        pulse_reset();
        s = '{8'h64};
        send_seq(s);
        repeat (2) @(negedge clk);
        checks++;
        if (stray_b != 1 || got_b.size() != 0) begin
            errors++; $display("FAIL reset_mid_msg strays=%0d msgs=%0d required 1/0", stray_b, got_b.size());
        end
    endtask

    task automatic test_random();
        int r;
        logic [7:0] b;
        clear_logs();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(99);
            if (r < 50)      b = 8'($urandom_range(127));
            else if (r < 75) b = 8'($urandom_range(8'hEF, 8'h80));
            else if (r < 80) b = (($urandom & 1) != 0) ? 8'h95 : 8'h9A;
            else if (r < 92) b = 8'($urandom_range(8'hFF, 8'hF8));
            else             b = 8'($urandom_range(8'hF7, 8'hF0));
            @(negedge clk);
            din = b; din_valid = 1'b1;
            model_step(b);
            repeat ($urandom_range(2)) begin
                @(negedge clk);
                din = 8'($urandom); din_valid = 1'b0;
            end
        end
        @(negedge clk); din_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
            errors++; $display("FAIL random_counts a=%0d/%0d b=%0d/%0d (got/required)", got_a.size(), exp_a.size(), got_b.size(), exp_b.size());
        end
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin errors++; $display("FAIL random_a[%0d] got=%h required %h", i, got_a[i], exp_a[i]); end
        end
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin errors++; $display("FAIL random_b[%0d] got=%h required %h", i, got_b[i], exp_b[i]); end
        end
        checks++;
        if (stray_a != exp_stray || stray_b != exp_stray) begin
            errors++; $display("FAIL random_stray a=%0d b=%0d required %0d", stray_a, stray_b, exp_stray);
        end
        checks++;
        if ({a_kind, a_chan, a_d1, a_d2} !== m_last_a || {b_kind, b_chan, b_d1, b_d2} !== m_last_b) begin
            errors++; $display("FAIL random_hold a=%h b=%h required %h %h", {a_kind, a_chan, a_d1, a_d2}, {b_kind, b_chan, b_d1, b_d2}, m_last_a, m_last_b);
        end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_realtime();
        test_one_byte_abort();
        test_stray_sysex();
        test_filter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
